// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the processor run controller: states, command opcodes,
// stop causes and the default program-end instruction word.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StStopped = 2'd1,
        StRun     = 2'd2,
        StStep    = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        CmdRun      = 2'd0,
        CmdStep     = 2'd1,
        CmdHalt     = 2'd2,
        CmdResetCpu = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        CauseCmd      = 2'd0,
        CauseBreak    = 2'd1,
        CauseHaltInsn = 2'd2,
        CauseBudget   = 2'd3
    } halt_cause_e;

    // beq $0,$0,-1 : a branch to itself marks the end of a program
    localparam logic [31:0] HaltWordDefault = 32'h1000FFFF;

endpackage

// File: rtl/budget_counter.sv
// Loadable 32-bit instruction budget down-counter. A zero load value means
// "unlimited", which the limited flag records; decrements only count when limited.
module budget_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [31:0] load_value_i,
    input  logic        dec_i,
    output logic        limited_o,
    output logic        zero_o
);

    logic [31:0] budget_q;
    logic        limited_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            budget_q  <= 32'd0;
            limited_q <= 1'b0;
        end else if (load_i) begin
            budget_q  <= load_value_i;
            limited_q <= (load_value_i != 32'd0);
        end else if (dec_i && limited_q && (budget_q != 32'd0)) begin
            budget_q <= budget_q - 32'd1;
        end
    end

    assign limited_o = limited_q;
    assign zero_o    = (budget_q == 32'd0);

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle processor: holds the core in reset, then
// sequences free/bounded runs and single steps, and counts retired instructions.
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 2,
    parameter logic [31:0] HALT_WORD    = HaltWordDefault
) (
    input  logic        clk,
    input  logic        start_up,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_arg,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        cpu_start_up,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    localparam int unsigned HoldW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldInit = HoldW'(RESET_CYCLES - 1);

    run_state_e     state_q;
    logic [HoldW-1:0] hold_q;
    logic [31:0]    retired_q;
    halt_cause_e    halt_cause_q;
    logic           skip_bp_q;

    logic           cmd_fire;
    logic           reset_cmd;
    logic           halt_cmd;
    logic           halt_insn;
    logic           bp_hit;
    logic           budget_hit;
    logic           stop;
    halt_cause_e    stop_cause;
    logic           budget_limited;
    logic           budget_zero;
    logic           budget_load;

    assign cmd_ready    = (state_q != StHold);
    assign cpu_start_up = (state_q == StHold);
    assign cmd_fire     = cmd_valid && cmd_ready;

    assign reset_cmd  = cmd_fire && (cmd_op == CmdResetCpu);
    assign halt_cmd   = cmd_fire && (cmd_op == CmdHalt);
    assign halt_insn  = (instruction == HALT_WORD);
    assign bp_hit     = bp_en && (pc == bp_addr) && !skip_bp_q;
    assign budget_hit = budget_limited && budget_zero;

    always_comb begin
        stop       = 1'b1;
        stop_cause = CauseCmd;
        if (halt_cmd) begin
            stop_cause = CauseCmd;
        end else if (halt_insn) begin
            stop_cause = CauseHaltInsn;
        end else if (bp_hit) begin
            stop_cause = CauseBreak;
        end else if (budget_hit) begin
            stop_cause = CauseBudget;
        end else begin
            stop = 1'b0;
        end
    end

    // A core reset or RESET_CPU in the same cycle suppresses retirement.
    always_comb begin
        cpu_en = 1'b0;
        case (state_q)
            StRun:   cpu_en = !stop;
            StStep:  cpu_en = 1'b1;
            default: cpu_en = 1'b0;
        endcase
        if (start_up || reset_cmd) begin
            cpu_en = 1'b0;
        end
    end

    assign budget_load = (state_q == StStopped) && cmd_fire && (cmd_op == CmdRun);

    budget_counter u_budget_counter (
        .clk_i        (clk),
        .rst_i        (start_up),
        .clear_i      (reset_cmd),
        .load_i       (budget_load),
        .load_value_i (cmd_arg),
        .dec_i        (cpu_en && (state_q == StRun)),
        .limited_o    (budget_limited),
        .zero_o       (budget_zero)
    );

    always_ff @(posedge clk) begin
        if (start_up) begin
            state_q      <= StHold;
            hold_q       <= HoldInit;
            retired_q    <= 32'd0;
            halt_cause_q <= CauseCmd;
            skip_bp_q    <= 1'b0;
        end else if (reset_cmd) begin
            state_q      <= StHold;
            hold_q       <= HoldInit;
            retired_q    <= 32'd0;
            halt_cause_q <= CauseCmd;
            skip_bp_q    <= 1'b0;
        end else begin
            if (cpu_en) begin
                retired_q <= retired_q + 32'd1;
            end
            case (state_q)
                StHold: begin
                    if (hold_q == '0) begin
                        state_q <= StStopped;
                    end else begin
                        hold_q <= hold_q - HoldW'(1);
                    end
                end
                StStopped: begin
                    if (cmd_fire && (cmd_op == CmdRun)) begin
                        state_q   <= StRun;
                        skip_bp_q <= 1'b1;
                    end else if (cmd_fire && (cmd_op == CmdStep)) begin
                        state_q <= StStep;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q      <= StStopped;
                        halt_cause_q <= stop_cause;
                    end else begin
                        skip_bp_q <= 1'b0;
                    end
                end
                StStep: begin
                    state_q <= StStopped;
                end
                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign halt_cause = halt_cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: reset hold, bounded run, breakpoints,
// halt word, HALT command, STEP, RESET_CPU and start_up mid-run.
module tb_proc_run_ctrl;

    logic        clk;
    logic        start_up;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        cpu_start_up;
    logic        cpu_en;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] HaltW = 32'h1000FFFF;

    proc_run_ctrl #(
        .RESET_CYCLES (2),
        .HALT_WORD    (HaltW)
    ) dut (
        .clk          (clk),
        .start_up     (start_up),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_arg      (cmd_arg),
        .pc           (pc),
        .instruction  (instruction),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .cpu_start_up (cpu_start_up),
        .cpu_en       (cpu_en),
        .state        (state),
        .halt_cause   (halt_cause),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // Issue a command for one edge; returns after that edge with valid dropped.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step_clk();
        cmd_valid = 1'b0;
    endtask

    // n cycles in which the core must retire; PC advances by 4 each edge.
    task automatic expect_retire(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            #1;
            check(tag, {31'd0, cpu_en}, 32'd1);
            step_clk();
            pc = pc + 32'd4;
        end
    endtask

    initial begin
        start_up    = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_arg     = 32'd0;
        pc          = 32'd0;
        instruction = 32'd0;
        bp_en       = 1'b0;
        bp_addr     = 32'd0;

        // Reset and hold release
        step_clk();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cpu_start_up", {31'd0, cpu_start_up}, 32'd1);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_retired", retired, 32'd0);
        start_up = 1'b0;
        step_clk();
        check("hold1_cpu_start_up", {31'd0, cpu_start_up}, 32'd1);
        step_clk();
        check("hold_done_state", {30'd0, state}, 32'd1);
        check("hold_done_cpu_start_up", {31'd0, cpu_start_up}, 32'd0);
        check("hold_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("hold_done_cause", {30'd0, halt_cause}, 32'd0);

        // Bounded RUN of 5
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_arg   = 32'd5;
        #1;
        check("stopped_cpu_en", {31'd0, cpu_en}, 32'd0);
        step_clk();
        cmd_valid = 1'b0;
        check("run5_state", {30'd0, state}, 32'd2);
        expect_retire(5, "run5_en");
        #1;
        check("run5_stop_cycle_en", {31'd0, cpu_en}, 32'd0);
        check("run5_stop_cycle_state", {30'd0, state}, 32'd2);
        step_clk();
        check("run5_state_after", {30'd0, state}, 32'd1);
        check("run5_cause", {30'd0, halt_cause}, 32'd3);
        check("run5_retired", retired, 32'd5);

        // Breakpoint at 0x0C, PC from 0
        pc      = 32'd0;
        bp_en   = 1'b1;
        bp_addr = 32'h0000000C;
        send_cmd(2'd0, 32'd0);
        expect_retire(3, "bp_en");
        #1;
        check("bp_hit_en", {31'd0, cpu_en}, 32'd0);
        step_clk();
        check("bp_state", {30'd0, state}, 32'd1);
        check("bp_cause", {30'd0, halt_cause}, 32'd1);
        check("bp_retired", retired, 32'd8);
        check("bp_pc_held", pc, 32'h0000000C);

        // Resume from breakpoint retires 0x0C, then HALT command stops it
        send_cmd(2'd0, 32'd0);
        expect_retire(3, "resume_en");
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        #1;
        check("halt_cmd_en", {31'd0, cpu_en}, 32'd0);
        step_clk();
        cmd_valid = 1'b0;
        check("halt_cmd_state", {30'd0, state}, 32'd1);
        check("halt_cmd_cause", {30'd0, halt_cause}, 32'd0);
        check("halt_cmd_retired", retired, 32'd11);

        // Halt word presented in the 7th run cycle
        bp_en = 1'b0;
        send_cmd(2'd0, 32'd0);
        expect_retire(6, "hw_en");
        instruction = HaltW;
        #1;
        check("hw_stop_en", {31'd0, cpu_en}, 32'd0);
        step_clk();
        check("hw_state", {30'd0, state}, 32'd1);
        check("hw_cause", {30'd0, halt_cause}, 32'd2);
        check("hw_retired", retired, 32'd17);

        // STEP over the halt word
        send_cmd(2'd1, 32'd0);
        check("step_state", {30'd0, state}, 32'd3);
        #1;
        check("step_en", {31'd0, cpu_en}, 32'd1);
        step_clk();
        check("step_after_state", {30'd0, state}, 32'd1);
        check("step_retired", retired, 32'd18);
        check("step_cause_kept", {30'd0, halt_cause}, 32'd2);

        // Halt word and breakpoint together: halt word wins
        instruction = 32'd0;
        bp_en       = 1'b1;
        bp_addr     = pc + 32'd4;
        send_cmd(2'd0, 32'd0);
        expect_retire(1, "prio_en");
        instruction = HaltW;
        #1;
        check("prio_stop_en", {31'd0, cpu_en}, 32'd0);
        step_clk();
        check("prio_cause", {30'd0, halt_cause}, 32'd2);
        check("prio_retired", retired, 32'd19);

        // RESET_CPU after 10 retirements
        instruction = 32'd0;
        bp_en       = 1'b0;
        send_cmd(2'd0, 32'd0);
        expect_retire(10, "rcpu_en");
        check("rcpu_retired_pre", retired, 32'd29);
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        #1;
        check("rcpu_cycle_en", {31'd0, cpu_en}, 32'd0);
        step_clk();
        cmd_valid = 1'b0;
        check("rcpu_state", {30'd0, state}, 32'd0);
        check("rcpu_cpu_start_up", {31'd0, cpu_start_up}, 32'd1);
        check("rcpu_retired", retired, 32'd0);
        check("rcpu_cause", {30'd0, halt_cause}, 32'd0);
        check("rcpu_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step_clk();
        check("rcpu_hold2", {31'd0, cpu_start_up}, 32'd1);
        step_clk();
        check("rcpu_released", {30'd0, state}, 32'd1);

        // Bounded RUN cleared by RESET_CPU must not leak a stale budget
        send_cmd(2'd0, 32'd3);
        expect_retire(3, "run3_en");
        #1;
        check("run3_stop_en", {31'd0, cpu_en}, 32'd0);
        step_clk();
        check("run3_cause", {30'd0, halt_cause}, 32'd3);

        // start_up mid-RUN overrides a pending command
        send_cmd(2'd0, 32'd0);
        expect_retire(2, "su_en");
        start_up  = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        step_clk();
        start_up  = 1'b0;
        cmd_valid = 1'b0;
        check("su_state", {30'd0, state}, 32'd0);
        check("su_retired", retired, 32'd0);
        check("su_cause", {30'd0, halt_cause}, 32'd0);
        step_clk();
        step_clk();
        check("su_released", {30'd0, state}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
